mult_div_seq: RTL and testbench

- Iterative signed multiply/divide engine with its own sequencer.
- Serves the mult and div R-type instructions. The main control unit, in its mult/div state, pulses a start and then waits on busy/done.
- Produces the 64-bit product or the quotient/remainder, plus write strobes for the HI/LO registers.
- Flags division by zero so the control unit can enter its DivZero exception state.

---
 rtl/mult_div_pkg.sv | 15 +
 rtl/mds_div_step.sv | 28 ++
 rtl/mult_div_seq.sv | 165 ++++++++++++++++
 tb/tb_mult_div_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide engine and the control unit.
package mult_div_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MULT   = 2'd1;
    localparam logic [1:0] ST_DIV    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // R-type funct codes decoded by the control unit before it pulses a start.
    localparam logic [5:0] Funct_Mult = 6'h18;
    localparam logic [5:0] Funct_Div  = 6'h1a;

endpackage

// File: rtl/mds_div_step.sv
// One restoring division step on unsigned magnitudes: shift in a dividend bit, trial-subtract.
module mds_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shift_s;
    logic [WIDTH:0] diff_s;

    // Trial subtraction; the top bit of the difference acts as the borrow.
    always_comb begin
        shift_s = {rem, quo[WIDTH-1]};
        diff_s  = shift_s - {1'b0, divisor};
        if (!diff_s[WIDTH]) begin
            rem_next = diff_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shift_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine with HI/LO write strobes.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             HI_writeControl,
    output logic             LO_writeControl,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   count_r;
    logic               busy_r, done_r, div_zero_r, hi_we_r, lo_we_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    // Booth product register: {guard+acc (WIDTH+1), multiplier (WIDTH), q_-1}
    logic [2*WIDTH+1:0] prod_r;
    logic [WIDTH:0]     mcand_r;
    logic [WIDTH:0]     booth_sum_s;
    logic [2*WIDTH+1:0] booth_next_s;

    logic [WIDTH-1:0]   rem_r, quo_r, dvsr_r;
    logic               neg_q_r, neg_r_r;
    logic [WIDTH-1:0]   div_rem_next_s, div_quo_next_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s;

    assign busy            = busy_r;
    assign done            = done_r;
    assign div_zero        = div_zero_r;
    assign HI_writeControl = hi_we_r;
    assign LO_writeControl = lo_we_r;
    assign hi_out          = hi_r;
    assign lo_out          = lo_r;

    // Booth recode of the two low bits, then arithmetic shift keeping the sign in the guard bit.
    always_comb begin
        case (prod_r[1:0])
            2'b01:   booth_sum_s = prod_r[2*WIDTH+1:WIDTH+1] + mcand_r;
            2'b10:   booth_sum_s = prod_r[2*WIDTH+1:WIDTH+1] - mcand_r;
            default: booth_sum_s = prod_r[2*WIDTH+1:WIDTH+1];
        endcase
        booth_next_s = {booth_sum_s[WIDTH], booth_sum_s, prod_r[WIDTH:1]};
    end

    // Operand magnitudes for the divider; -2^(WIDTH-1) maps onto itself as an unsigned value.
    always_comb begin
        abs_a_s = op_a[WIDTH-1] ? ({WIDTH{1'b0}} - op_a) : op_a;
        abs_b_s = op_b[WIDTH-1] ? ({WIDTH{1'b0}} - op_b) : op_b;
    end

    mds_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvsr_r),
        .rem_next (div_rem_next_s),
        .quo_next (div_quo_next_s)
    );

    // Sequencer: start arbitration, iteration counting, result load and strobe generation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            count_r    <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_we_r    <= 1'b0;
            lo_we_r    <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            prod_r     <= {(2*WIDTH+2){1'b0}};
            mcand_r    <= {(WIDTH+1){1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            dvsr_r     <= {WIDTH{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_we_r    <= 1'b0;
            lo_we_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_mult) begin
                        prod_r  <= {{(WIDTH+1){1'b0}}, op_b, 1'b0};
                        mcand_r <= {op_a[WIDTH-1], op_a};
                        count_r <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_MULT;
                    end else if (start_div) begin
                        busy_r <= 1'b1;
                        if (op_b == {WIDTH{1'b0}}) begin
                            done_r     <= 1'b1;
                            div_zero_r <= 1'b1;
                            state_r    <= ST_FINISH;
                        end else begin
                            rem_r   <= {WIDTH{1'b0}};
                            quo_r   <= abs_a_s;
                            dvsr_r  <= abs_b_s;
                            neg_q_r <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r_r <= op_a[WIDTH-1];
                            count_r <= {CNT_W{1'b0}};
                            state_r <= ST_DIV;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_MULT: begin
                    prod_r  <= booth_next_s;
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == CNT_W'(WIDTH-1)) begin
                        hi_r    <= booth_next_s[2*WIDTH:WIDTH+1];
                        lo_r    <= booth_next_s[WIDTH:1];
                        done_r  <= 1'b1;
                        hi_we_r <= 1'b1;
                        lo_we_r <= 1'b1;
                        count_r <= {CNT_W{1'b0}};
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_MULT;
                    end
                end
                ST_DIV: begin
                    rem_r   <= div_rem_next_s;
                    quo_r   <= div_quo_next_s;
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_r == CNT_W'(WIDTH-1)) begin
                        hi_r    <= neg_r_r ? ({WIDTH{1'b0}} - div_rem_next_s) : div_rem_next_s;
                        lo_r    <= neg_q_r ? ({WIDTH{1'b0}} - div_quo_next_s) : div_quo_next_s;
                        done_r  <= 1'b1;
                        hi_we_r <= 1'b1;
                        lo_we_r <= 1'b1;
                        count_r <= {CNT_W{1'b0}};
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq against a plain-arithmetic reference model.
module tb_mult_div_seq;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        HI_writeControl;
    logic        LO_writeControl;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;

    mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock           (clock),
        .reset           (reset),
        .start_mult      (start_mult),
        .start_div       (start_div),
        .op_a            (op_a),
        .op_b            (op_b),
        .busy            (busy),
        .done            (done),
        .div_zero        (div_zero),
        .HI_writeControl (HI_writeControl),
        .LO_writeControl (LO_writeControl),
        .hi_out          (hi_out),
        .lo_out          (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Issue one start (optionally injecting a start_div pulse k cycles in) and check everything.
    task automatic run_op(input string tag, input logic sm, input logic sd,
                          input logic [31:0] a, input logic [31:0] b, input int inject_k);
        longint p, qa, qb, q, r;
        logic [31:0] exp_hi, exp_lo;
        logic        exp_dz;
        int          exp_lat;
        int          k;
        logic        got;
        int          early_we;
        logic        busy_dropped;

        if (sm) begin
            p = longint'($signed(a)) * longint'($signed(b));
            exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dz = 1'b0; exp_lat = 32;
        end else if (b == 32'h0) begin
            exp_hi = prev_hi; exp_lo = prev_lo; exp_dz = 1'b1; exp_lat = 0;
        end else begin
            qa = longint'($signed(a)); qb = longint'($signed(b));
            q = qa / qb; r = qa % qb;
            exp_hi = r[31:0]; exp_lo = q[31:0]; exp_dz = 1'b0; exp_lat = 32;
        end

        @(negedge clock);
        check1({tag, "_idle_busy"}, busy, 1'b0);
        start_mult = sm; start_div = sd; op_a = a; op_b = b;
        @(posedge clock);
        @(negedge clock);
        start_mult = 1'b0; start_div = 1'b0; op_a = $urandom; op_b = $urandom;

        k = 0; got = 1'b0; early_we = 0; busy_dropped = 1'b0;
        while (k <= 40) begin
            start_div = (k == inject_k) ? 1'b1 : 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!busy) busy_dropped = 1'b1;
            if (HI_writeControl || LO_writeControl) early_we++;
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        start_div = 1'b0;

        check1({tag, "_done_seen"}, got, 1'b1);
        if (got) begin
            check({tag, "_latency"}, k, exp_lat);
            check({tag, "_early_strobes"}, early_we, 0);
            check1({tag, "_busy_run"}, busy_dropped, 1'b0);
            check1({tag, "_busy_fin"}, busy, 1'b1);
            check1({tag, "_div_zero"}, div_zero, exp_dz);
            check1({tag, "_hi_we"}, HI_writeControl, ~exp_dz);
            check1({tag, "_lo_we"}, LO_writeControl, ~exp_dz);
            check({tag, "_hi"}, hi_out, exp_hi);
            check({tag, "_lo"}, lo_out, exp_lo);
            @(posedge clock);
            @(negedge clock);
            check1({tag, "_done_after"}, done, 1'b0);
            check1({tag, "_busy_after"}, busy, 1'b0);
            check1({tag, "_we_after"}, HI_writeControl | LO_writeControl, 1'b0);
            check({tag, "_hi_hold"}, hi_out, exp_hi);
            check({tag, "_lo_hold"}, lo_out, exp_lo);
        end
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; op_a = 32'h0; op_b = 32'h0;
        repeat (2) @(negedge clock);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_we", HI_writeControl | LO_writeControl, 1'b0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        reset = 1'b1;

        run_op("mul_7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, -1);
        run_op("mul_maxpos", 1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1);
        run_op("mul_minneg", 1'b1, 1'b0, 32'h80000000, 32'h80000000, -1);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, -1);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1);
        run_op("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, -1);
        run_op("mul_inject", 1'b1, 1'b0, 32'h12345678, 32'hFEDCBA98, 9);
        run_op("both_starts", 1'b1, 1'b1, 32'hFFFF0001, 32'd1000, -1);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; sel = $urandom_range(0, 5);
            if (sel == 0) rb = 32'h0;
            if (sel == 1) rb = $urandom_range(1, 9);
            if (sel == 2) ra = 32'h80000000;
            run_op("rand", (sel > 3) ? 1'b1 : 1'b0, (sel <= 3) ? 1'b1 : 1'b0, ra, rb, -1);
        end

        // Asynchronous reset in the middle of a divide.
        run_op("pre_abort", 1'b1, 1'b0, 32'h00010003, 32'h00020005, -1);
        @(negedge clock);
        start_div = 1'b1; op_a = 32'hFFFF1234; op_b = 32'd77;
        @(posedge clock);
        @(negedge clock);
        start_div = 1'b0;
        repeat (14) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        check1("abort_dz", div_zero, 1'b0);
        check1("abort_we", HI_writeControl | LO_writeControl, 1'b0);
        check("abort_hi", hi_out, 32'h0);
        check("abort_lo", lo_out, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        prev_hi = 32'h0;
        prev_lo = 32'h0;
        repeat (3) begin
            @(negedge clock);
            check1("abort_no_done", done, 1'b0);
        end
        run_op("post_abort", 1'b1, 1'b0, 32'hFFFFFFF0, 32'h00000011, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
